// File: rtl/uart_apb_pkg.sv
// uart_apb_pkg -- shared definitions for the UART APB register slave.
//   Register byte offsets, FSM state encoding, CTRL command codes,
//   STATUS bit positions and the decoded register-select record.
package uart_apb_pkg;

  localparam int OFF_TR     = 'h00;
  localparam int OFF_CTRL   = 'h04;
  localparam int OFF_BAUD   = 'h08;
  localparam int OFF_STATUS = 'h0C;

  localparam logic [6:0] CTRL_TX = 7'h01;
  localparam logic [6:0] CTRL_RX = 7'h02;

  localparam int STAT_TXBUSY_BIT  = 0;
  localparam int STAT_TIMEOUT_BIT = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef struct packed {
    logic tr;
    logic ctrl;
    logic baud;
    logic status;
  } reg_sel_t;

  function automatic logic [31:0] status_word(input logic timeout, input logic busy);
    status_word = '0;
    status_word[STAT_TIMEOUT_BIT] = timeout;
    status_word[STAT_TXBUSY_BIT]  = busy;
  endfunction

endpackage

// File: rtl/uart_apb_slv_if.sv
// uart_apb_slv_if -- APB3 bus bundle between a master and the UART slave.
//   psel/penable/pwrite/paddr/pwdata : master -> slave
//   prdata/pready/pslverr            : slave -> master
interface uart_apb_slv_if #(
  parameter int ADDR_W = 8
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       pwdata;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/uart_apb_decode.sv
// uart_apb_decode -- combinational register decode.
//   addr_i     : latched APB address (byte address, low two bits ignored)
//   sel_o      : one-hot register select (TR/CTRL/BAUD/STATUS)
//   mapped_o   : address hits any register
//   writable_o : address hits a writable register (TR/CTRL/BAUD)
module uart_apb_decode
  import uart_apb_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic [ADDR_W-1:0] addr_i,
  output reg_sel_t          sel_o,
  output logic              mapped_o,
  output logic              writable_o
);
  localparam int WA_W = ADDR_W - 2;

  logic [WA_W-1:0] word;
  logic            unused_lsb;

  assign word       = addr_i[ADDR_W-1:2];
  assign unused_lsb = ^addr_i[1:0];

  always_comb begin
    sel_o        = '0;
    sel_o.tr     = (word == WA_W'(OFF_TR >> 2));
    sel_o.ctrl   = (word == WA_W'(OFF_CTRL >> 2));
    sel_o.baud   = (word == WA_W'(OFF_BAUD >> 2));
    sel_o.status = (word == WA_W'(OFF_STATUS >> 2));
    mapped_o     = |sel_o;
    writable_o   = sel_o.tr | sel_o.ctrl | sel_o.baud;
  end
endmodule

// File: rtl/uart_apb_slv.sv
// uart_apb_slv -- APB3 slave front-end for a UART datapath.
//   clk, rst             : clock, synchronous active-high reset
//   bus (slave modport)  : APB3 psel/penable/pwrite/paddr/pwdata -> prdata/pready/pslverr
//   sel_tr/sel_ctrl/sel_baud/enable : one-cycle datapath strobes
//   data_out             : write data to the datapath
//   data_in              : received byte from the datapath
//   tx_en                : transmitter busy; stalls TR writes
// Optional macro UART_APB_PSLVERR_EN: report unmapped accesses, STATUS
// writes and busy-wait timeouts on pslverr (otherwise pslverr stays 0).
module uart_apb_slv
  import uart_apb_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int WAIT_MAX = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_apb_slv_if.slave        bus,
  output logic                 sel_tr,
  output logic                 sel_ctrl,
  output logic                 sel_baud,
  output logic                 enable,
  output logic [31:0]          data_out,
  input  logic [31:0]          data_in,
  input  logic                 tx_en
);
`ifdef UART_APB_PSLVERR_EN
  localparam logic SLVERR_EN = 1'b1;
`else
  localparam logic SLVERR_EN = 1'b0;
`endif
  localparam int WAIT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [6:0]        ctrl_q, ctrl_d;
  logic [19:0]       baud_q, baud_d;
  logic              tmo_q, tmo_d;
  logic [31:0]       data_out_q, data_out_d;
  logic [31:0]       prdata_q, prdata_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic              sel_tr_q, sel_tr_d;
  logic              sel_ctrl_q, sel_ctrl_d;
  logic              sel_baud_q, sel_baud_d;
  logic              enable_q, enable_d;

  reg_sel_t dec_sel;
  logic     dec_map;
  logic     dec_wr;

  uart_apb_decode #(.ADDR_W(ADDR_W)) u_decode (
    .addr_i     (addr_q),
    .sel_o      (dec_sel),
    .mapped_o   (dec_map),
    .writable_o (dec_wr)
  );

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    wdata_d    = wdata_q;
    ctrl_d     = ctrl_q;
    baud_d     = baud_q;
    tmo_d      = tmo_q;
    data_out_d = data_out_q;
    prdata_d   = '0;
    pready_d   = 1'b0;
    pslverr_d  = 1'b0;
    sel_tr_d   = 1'b0;
    sel_ctrl_d = 1'b0;
    sel_baud_d = 1'b0;
    enable_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.psel && !bus.penable) begin
          addr_d  = bus.paddr;
          wr_d    = bus.pwrite;
          wdata_d = bus.pwdata;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!bus.psel) begin
          // master abandoned the transfer: no response, no side effects
          state_d = ST_IDLE;
          wait_d  = '0;
        end else if (wr_q && dec_sel.tr && tx_en) begin
          if (wait_q == WAIT_W'(WAIT_MAX)) begin
            state_d   = ST_DONE;
            wait_d    = '0;
            pready_d  = 1'b1;
            pslverr_d = SLVERR_EN;
            tmo_d     = 1'b1;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end else begin
          // response and strobes are registered so they line up with DONE
          state_d  = ST_DONE;
          wait_d   = '0;
          pready_d = 1'b1;
          if (wr_q) begin
            if (dec_wr) begin
              data_out_d = wdata_q;
              enable_d   = 1'b1;
              sel_tr_d   = dec_sel.tr;
              sel_ctrl_d = dec_sel.ctrl;
              sel_baud_d = dec_sel.baud;
            end else begin
              pslverr_d = SLVERR_EN;
            end
            if (dec_sel.ctrl) ctrl_d = wdata_q[6:0];
            if (dec_sel.baud) baud_d = wdata_q[19:0];
          end else begin
            if (!dec_map) pslverr_d = SLVERR_EN;
            if (dec_sel.tr) begin
              prdata_d = data_in;
              sel_tr_d = 1'b1;
              enable_d = 1'b1;
            end
            if (dec_sel.ctrl) prdata_d = {25'b0, ctrl_q};
            if (dec_sel.baud) prdata_d = {12'b0, baud_q};
            if (dec_sel.status) begin
              prdata_d = status_word(tmo_q, tx_en);
              tmo_d    = 1'b0;
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wait_q     <= '0;
      ctrl_q     <= '0;
      baud_q     <= '0;
      tmo_q      <= 1'b0;
      data_out_q <= '0;
      prdata_q   <= '0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      sel_tr_q   <= 1'b0;
      sel_ctrl_q <= 1'b0;
      sel_baud_q <= 1'b0;
      enable_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      ctrl_q     <= ctrl_d;
      baud_q     <= baud_d;
      tmo_q      <= tmo_d;
      data_out_q <= data_out_d;
      prdata_q   <= prdata_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      sel_tr_q   <= sel_tr_d;
      sel_ctrl_q <= sel_ctrl_d;
      sel_baud_q <= sel_baud_d;
      enable_q   <= enable_d;
    end
    addr_q  <= addr_d;
    wr_q    <= wr_d;
    wdata_q <= wdata_d;
  end

  assign bus.prdata  = prdata_q;
  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;
  assign sel_tr      = sel_tr_q;
  assign sel_ctrl    = sel_ctrl_q;
  assign sel_baud    = sel_baud_q;
  assign enable      = enable_q;
  assign data_out    = data_out_q;
endmodule

// File: tb/tb_uart_apb_slv.sv
module tb_uart_apb_slv;
`ifdef UART_APB_PSLVERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite, use_b;
  logic [7:0]  paddr;
  logic [31:0] pwdata, data_in;
  logic        tx_en;

  always #5 clk = ~clk;

  uart_apb_slv_if #(.ADDR_W(8)) bus_a ();
  uart_apb_slv_if #(.ADDR_W(8)) bus_b ();

  assign bus_a.psel    = psel & ~use_b;
  assign bus_a.penable = penable & ~use_b;
  assign bus_a.pwrite  = pwrite;
  assign bus_a.paddr   = paddr;
  assign bus_a.pwdata  = pwdata;
  assign bus_b.psel    = psel & use_b;
  assign bus_b.penable = penable & use_b;
  assign bus_b.pwrite  = pwrite;
  assign bus_b.paddr   = paddr;
  assign bus_b.pwdata  = pwdata;

  logic        str_a, sctl_a, sbd_a, en_a, str_b, sctl_b, sbd_b, en_b;
  logic [31:0] dout_a, dout_b;

  uart_apb_slv #(.ADDR_W(8), .WAIT_MAX(255)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a),
    .sel_tr(str_a), .sel_ctrl(sctl_a), .sel_baud(sbd_a), .enable(en_a),
    .data_out(dout_a), .data_in(data_in), .tx_en(tx_en)
  );

  uart_apb_slv #(.ADDR_W(8), .WAIT_MAX(8)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b),
    .sel_tr(str_b), .sel_ctrl(sctl_b), .sel_baud(sbd_b), .enable(en_b),
    .data_out(dout_b), .data_in(data_in), .tx_en(tx_en)
  );

  logic [31:0] prdata_o, dout_o;
  logic [2:0]  sel_o;
  logic        pready_o, err_o, en_o;
  assign prdata_o = use_b ? bus_b.prdata  : bus_a.prdata;
  assign pready_o = use_b ? bus_b.pready  : bus_a.pready;
  assign err_o    = use_b ? bus_b.pslverr : bus_a.pslverr;
  assign sel_o    = use_b ? {str_b, sctl_b, sbd_b} : {str_a, sctl_a, sbd_a};
  assign en_o     = use_b ? en_b : en_a;
  assign dout_o   = use_b ? dout_b : dout_a;

  typedef struct {
    logic [31:0] rdata;
    logic [2:0]  sel;
    logic        en;
    logic [31:0] dout;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_chk  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One APB transfer; the expected response is queued at setup and
  // popped when pready is seen.
  task automatic xfer(input logic wr, input logic [7:0] a, input logic [31:0] d,
                      input logic [31:0] rdata, input logic [2:0] sel,
                      input logic [31:0] dout, input logic err, input int lat);
    exp_t e;
    int   cyc;
    e.rdata = rdata; e.sel = sel; e.en = |sel; e.dout = dout; e.err = err; e.lat = lat;
    sb.push_back(e);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    tick();
    penable = 1'b1;
    cyc = 1;
    while (pready_o !== 1'b1 && cyc < 300) begin
      tick();
      cyc++;
    end
    e = sb.pop_front();
    chk("latency",  32'(cyc), 32'(e.lat));
    chk("prdata",   prdata_o, e.rdata);
    chk("sel",      32'(sel_o), 32'(e.sel));
    chk("enable",   32'(en_o), 32'(e.en));
    chk("data_out", dout_o, e.dout);
    chk("pslverr",  32'(err_o), 32'(e.err));
    psel = 1'b0; penable = 1'b0;
    tick();
    chk("pready_1cyc", 32'(pready_o), 32'd0);
    chk("strobe_1cyc", {28'd0, en_o, sel_o}, 32'd0);
    chk("prdata_idle", prdata_o, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
    pwdata = '0; data_in = '0; tx_en = 1'b0; use_b = 1'b0;
    repeat (3) tick();
    chk("rst_prdata", prdata_o, 32'd0);
    chk("rst_pready", 32'(pready_o), 32'd0);
    chk("rst_pslverr", 32'(err_o), 32'd0);
    chk("rst_strobes", {28'd0, en_o, sel_o}, 32'd0);
    chk("rst_data_out", dout_o, 32'd0);
    rst = 1'b0;
    tick();

    // CTRL write then read back
    xfer(1'b1, 8'h04, 32'h1, 32'h0, 3'b010, 32'h1, 1'b0, 2);
    xfer(1'b0, 8'h04, 32'h0, 32'h1, 3'b000, 32'h1, 1'b0, 2);
    // CTRL keeps 7 bits; address low bits ignored
    xfer(1'b1, 8'h04, 32'hFF, 32'h0, 3'b010, 32'hFF, 1'b0, 2);
    xfer(1'b0, 8'h07, 32'h0, 32'h7F, 3'b000, 32'hFF, 1'b0, 2);
    // BAUD keeps 20 bits
    xfer(1'b1, 8'h08, 32'hFFFF_FFFF, 32'h0, 3'b001, 32'hFFFF_FFFF, 1'b0, 2);
    xfer(1'b0, 8'h08, 32'h0, 32'hF_FFFF, 3'b000, 32'hFFFF_FFFF, 1'b0, 2);
    xfer(1'b1, 8'h08, 32'h1B2, 32'h0, 3'b001, 32'h1B2, 1'b0, 2);
    xfer(1'b0, 8'h0A, 32'h0, 32'h1B2, 3'b000, 32'h1B2, 1'b0, 2);

    // TR write stalled by a busy transmitter for 10 access cycles
    tx_en = 1'b1;
    fork
      xfer(1'b1, 8'h00, 32'hA5, 32'h0, 3'b100, 32'hA5, 1'b0, 12);
      begin
        repeat (11) @(posedge clk);
        #1 tx_en = 1'b0;
      end
    join

    // TR read, unmapped read, STATUS write, STATUS read
    data_in = 32'h5A;
    xfer(1'b0, 8'h00, 32'h0, 32'h5A, 3'b100, 32'hA5, 1'b0, 2);
    xfer(1'b0, 8'h10, 32'h0, 32'h0, 3'b000, 32'hA5, ERR, 2);
    xfer(1'b1, 8'h0C, 32'h7, 32'h0, 3'b000, 32'hA5, ERR, 2);
    xfer(1'b0, 8'h0C, 32'h0, 32'h0, 3'b000, 32'hA5, 1'b0, 2);

    // protocol abort: psel dropped in the access phase
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h04; pwdata = 32'h33;
    tick();
    psel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_pready", 32'(pready_o), 32'd0);
      chk("abort_strobe", {28'd0, en_o, sel_o}, 32'd0);
    end
    xfer(1'b0, 8'h04, 32'h0, 32'h7F, 3'b000, 32'hA5, 1'b0, 2);

    // reset during the access phase of a BAUD write
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h08; pwdata = 32'h1B2;
    tick();
    penable = 1'b1; rst = 1'b1;
    tick();
    chk("rstmid_pready", 32'(pready_o), 32'd0);
    chk("rstmid_strobe", {28'd0, en_o, sel_o}, 32'd0);
    chk("rstmid_data_out", dout_o, 32'd0);
    chk("rstmid_prdata", prdata_o, 32'd0);
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    tick();
    chk("rstmid_idle_strobe", {28'd0, en_o, sel_o}, 32'd0);
    xfer(1'b0, 8'h08, 32'h0, 32'h0, 3'b000, 32'h0, 1'b0, 2);
    xfer(1'b0, 8'h04, 32'h0, 32'h0, 3'b000, 32'h0, 1'b0, 2);

    // busy-wait timeout on the WAIT_MAX=8 instance
    use_b = 1'b1; tx_en = 1'b1;
    tick();
    xfer(1'b1, 8'h00, 32'hDEAD, 32'h0, 3'b000, 32'h0, ERR, 10);
    xfer(1'b0, 8'h0C, 32'h0, 32'h5, 3'b000, 32'h0, 1'b0, 2);
    xfer(1'b0, 8'h0C, 32'h0, 32'h1, 3'b000, 32'h0, 1'b0, 2);
    tx_en = 1'b0;
    xfer(1'b0, 8'h0C, 32'h0, 32'h0, 3'b000, 32'h0, 1'b0, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_apb_slv.md
UART_APB_SLV -- requirements
Module: uart_apb_slv

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, APB address width.
REQ-002 SHALL have parameter WAIT_MAX, default 255, maximum busy-wait cycles before timeout.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports psel, penable, pwrite  input  1 each  APB3 control.
REQ-006 SHALL have ports paddr  input  ADDR_W and pwdata  input  32  APB address and write data.
REQ-007 SHALL have ports prdata  output  32, pready  output  1, pslverr  output  1  APB response.
REQ-008 SHALL have ports sel_tr, sel_ctrl, sel_baud, enable  output  1 each  downstream datapath strobes.
REQ-009 SHALL have port data_out  output  32  write data to datapath.
REQ-010 SHALL have ports data_in  input  32 (received byte) and tx_en  input  1 (transmitter busy).

Function
REQ-011 SHALL implement FSM states IDLE, ACCESS, DONE; all outputs registered.
REQ-012 IDLE: psel=1, penable=0 -> latch paddr/pwrite/pwdata, go ACCESS.
REQ-013 ACCESS: psel=0 (protocol abort) -> IDLE, no strobe, no pready.
REQ-014 ACCESS: write to 0x00 while tx_en=1 -> stay ACCESS, pready=0, wait counter +1.
REQ-015 ACCESS: otherwise -> DONE next cycle; minimum latency setup-to-pready = 2 cycles (one wait state).
REQ-016 Wait counter reaching WAIT_MAX -> DONE with timeout flag set, no strobe; counter cleared on leaving ACCESS.
REQ-017 DONE: pready=1 for exactly one cycle, then IDLE; IDLE samples the next setup in the following cycle (back-to-back supported).
REQ-018 Register map: 0x00 TR (sel_tr), 0x04 CTRL (sel_ctrl), 0x08 BAUD (sel_baud), 0x0C STATUS (read-only); paddr[1:0] ignored.
REQ-019 DONE for mapped TR/CTRL/BAUD write: assert matching sel_* and enable for that one cycle, data_out=latched pwdata.
REQ-020 DONE for TR read: assert sel_tr and enable for one cycle, data_out unchanged; prdata=data_in.
REQ-021 Shadow registers: ctrl_q[6:0] and baud_q[19:0] updated on CTRL/BAUD writes; reads return zero-extended shadows.
REQ-022 STATUS read: prdata={29'b0, timeout_sticky, 1'b0, tx_en}; timeout_sticky set on timeout, cleared by any STATUS read.
REQ-023 Unmapped address or STATUS write: completes normally, no strobe, prdata=0.
REQ-024 prdata SHALL be 0 outside DONE; at most one sel_* high in any cycle; enable high only with a sel_*.

Reset
REQ-025 rst=1 SHALL force IDLE, clear wait counter, ctrl_q, baud_q, timeout_sticky, data_out, prdata, and drive pready, pslverr, sel_*, enable to 0, including mid-transfer.

Configuration
REQ-026 With UART_APB_PSLVERR_EN defined: pslverr=1 in DONE for unmapped address, STATUS write, or timeout.
REQ-027 Without UART_APB_PSLVERR_EN: pslverr tied 0; same cases complete silently.

Structure
REQ-028 Package uart_apb_pkg SHALL hold register offsets, FSM state enum, CTRL codes (TX=7'h01, RX=7'h02), STATUS bit positions.
REQ-029 Address decode SHALL be one combinational sub-module uart_apb_decode (paddr -> one-hot select, mapped, writable flags).

Verification
REQ-030 Write 0x04 data 0x01 -> pready at cycle 2, sel_ctrl=enable=1 same cycle, data_out=0x1, read 0x04 returns 0x1.
REQ-031 Write 0x00 data 0xA5 with tx_en=1 for 10 cycles -> pready low 10 cycles, then pready and sel_tr with data_out=0xA5.
REQ-032 tx_en stuck 1, WAIT_MAX=8 -> DONE after 8 wait cycles, no strobe, pslverr=1 (macro on) / 0 (off); STATUS bit2=1, then 0 on reread.
REQ-033 Read 0x00 with data_in=0x5A -> prdata=0x5A, sel_tr=enable=1 one cycle; read 0x10 -> prdata=0, no strobe.
REQ-034 rst asserted during ACCESS of a BAUD write 0x1B2 -> no sel_baud, all outputs 0, later BAUD read returns 0.
